// File: rtl/ir_pkg.sv
// ============================================================================
//  Module   : ir_pkg
//  Purpose  : Shared types and constants for the IR line-sensor scan block:
//             scan state encoding and the default line-detect threshold.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ir_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } ir_state_e;

    // Default line-detect threshold for a 12-bit A2D result
    localparam logic [11:0] c_LINE_THRES_DEF = 12'h040;

endpackage

`default_nettype wire

// File: rtl/ir_round_timer.sv
// ============================================================================
//  Module   : ir_round_timer
//  Purpose  : Free-running round-period counter. Counts 0..ROUND_CYC-1 and
//             wraps; o_tick is high for the single cycle at the final count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_round_timer #(
    parameter int unsigned ROUND_CYC = 262144
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned          c_CNT_W = (ROUND_CYC > 1) ? $clog2(ROUND_CYC) : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(ROUND_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tick;

    assign w_tick = (r_cnt == c_LAST);
    assign o_tick = w_tick;

    // Round counter: wraps to zero on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ir_scan_ctrl.sv
// ============================================================================
//  Module   : ir_scan_ctrl
//  Purpose  : Periodic IR line-sensor scan. Each round period the emitters
//             are enabled, allowed to settle, then every channel is converted
//             through the A2D handshake. Results are stored per channel and
//             the strongest channel / line-present flag are published.
//  Config   : IR_OVERSAMPLE_EN - when defined, each channel is converted
//             2**AVG_LOG2 times and the truncated average is stored. When
//             undefined, one conversion per channel is stored directly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_scan_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned      NUM_CH     = 8,
    parameter int unsigned      RES_W      = 12,
    parameter int unsigned      ROUND_CYC  = 262144,
    parameter int unsigned      SETTLE_CYC = 4096,
    parameter logic [RES_W-1:0] LINE_THRES = RES_W'(c_LINE_THRES_DEF),
    parameter int unsigned      AVG_LOG2   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        strt_cnv,
    output logic [$clog2(NUM_CH)-1:0]   chnnl,
    input  logic                        cnv_cmplt,
    input  logic [RES_W-1:0]            res,
    output logic                        IR_en,
    output logic [NUM_CH*RES_W-1:0]     ir_vals,
    output logic                        IR_vld,
    output logic                        line_present,
    output logic [$clog2(NUM_CH)-1:0]   max_ch,
    output logic                        scan_ovr
);

    localparam int unsigned          c_CH_W     = $clog2(NUM_CH);
    localparam logic [c_CH_W-1:0]    c_LAST_CH  = c_CH_W'(NUM_CH - 1);
    localparam int unsigned          c_SET_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [c_SET_W-1:0]   c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
`ifdef IR_OVERSAMPLE_EN
    localparam int unsigned          c_SMP_LOG2 = AVG_LOG2;
`else
    // Averaging compiled out: exactly one sample per channel
    localparam int unsigned          c_SMP_LOG2 = AVG_LOG2 * 0;
`endif
    localparam int unsigned          c_SMP_W    = (c_SMP_LOG2 > 0) ? c_SMP_LOG2 : 1;
    localparam logic [c_SMP_W-1:0]   c_SMP_LAST = c_SMP_W'((1 << c_SMP_LOG2) - 1);

    ir_state_e          r_state;
    ir_state_e          w_state_nxt;
    logic               w_tick;
    logic [c_SET_W-1:0] r_settle;
    logic [c_SMP_W-1:0] r_smp;
    logic [c_CH_W-1:0]  r_chnnl;
    logic               r_strt;
    logic [NUM_CH*RES_W-1:0] r_ir_vals;
    logic [RES_W-1:0]   r_max_val;
    logic [c_CH_W-1:0]  r_run_max_ch;
    logic [c_CH_W-1:0]  r_max_ch;
    logic               r_line;
    logic               r_scan_ovr;
    logic [RES_W-1:0]   w_avg;

    // FSM strobes
    logic w_round_start;
    logic w_sample;
    logic w_final;
    logic w_adv_ch;
    logic w_publish;
    logic w_strt_nxt;
    logic w_ir_en;
    logic w_ir_vld;

    ir_round_timer #(
        .ROUND_CYC (ROUND_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; completions outside CONV are ignored
    always_comb begin
        w_state_nxt   = r_state;
        w_round_start = 1'b0;
        w_sample      = 1'b0;
        w_final       = 1'b0;
        w_adv_ch      = 1'b0;
        w_publish     = 1'b0;
        w_strt_nxt    = 1'b0;
        w_ir_en       = (r_state != ST_IDLE);
        w_ir_vld      = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt   = ST_SETTLE;
                    w_round_start = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_settle == c_SET_LAST) begin
                    w_state_nxt = ST_CONV;
                    w_strt_nxt  = 1'b1;
                end
            end
            ST_CONV: begin
                if (cnv_cmplt) begin
                    w_sample = 1'b1;
                    if (r_smp == c_SMP_LAST) begin
                        w_final     = 1'b1;
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_strt_nxt  = 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (r_chnnl == c_LAST_CH) begin
                    w_state_nxt = ST_DONE;
                    w_publish   = 1'b1;
                end else begin
                    w_state_nxt = ST_CONV;
                    w_adv_ch    = 1'b1;
                    w_strt_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef IR_OVERSAMPLE_EN
    localparam int unsigned c_ACC_W = RES_W + AVG_LOG2;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_sum;

    assign w_sum = r_acc + c_ACC_W'(res);
    // Truncating divide by 2**AVG_LOG2: keep the upper RES_W bits of the sum
    assign w_avg = w_sum[c_ACC_W-1 -: RES_W];

    // Per-channel accumulator, cleared at round start and on channel advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_round_start || w_adv_ch) begin
            r_acc <= '0;
        end else if (w_sample) begin
            r_acc <= w_sum;
        end
    end
`else
    assign w_avg = res;
`endif

    // Scan datapath: counters, channel slots, running maximum, published flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle     <= '0;
            r_smp        <= '0;
            r_chnnl      <= '0;
            r_strt       <= 1'b0;
            r_ir_vals    <= '0;
            r_max_val    <= '0;
            r_run_max_ch <= '0;
            r_max_ch     <= '0;
            r_line       <= 1'b0;
            r_scan_ovr   <= 1'b0;
        end else begin
            r_strt     <= w_strt_nxt;
            r_scan_ovr <= w_tick && (r_state != ST_IDLE);

            if (w_round_start) begin
                r_settle     <= '0;
                r_smp        <= '0;
                r_chnnl      <= '0;
                r_max_val    <= '0;
                r_run_max_ch <= '0;
            end

            if (r_state == ST_SETTLE) begin
                r_settle <= r_settle + c_SET_W'(1);
            end

            if (w_sample) begin
                r_smp <= w_final ? '0 : (r_smp + c_SMP_W'(1));
            end

            if (w_final) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (r_chnnl == c_CH_W'(k)) begin
                        r_ir_vals[k*RES_W +: RES_W] <= w_avg;
                    end
                end
                // Strict compare keeps the lower channel on ties
                if (w_avg > r_max_val) begin
                    r_max_val    <= w_avg;
                    r_run_max_ch <= r_chnnl;
                end
            end

            if (w_adv_ch) begin
                r_chnnl <= r_chnnl + c_CH_W'(1);
            end

            if (w_publish) begin
                r_max_ch <= r_run_max_ch;
                r_line   <= (r_max_val > LINE_THRES);
            end
        end
    end

    assign strt_cnv     = r_strt;
    assign chnnl        = r_chnnl;
    assign IR_en        = w_ir_en;
    assign ir_vals      = r_ir_vals;
    assign IR_vld       = w_ir_vld;
    assign line_present = r_line;
    assign max_ch       = r_max_ch;
    assign scan_ovr     = r_scan_ovr;

endmodule

`default_nettype wire

// File: doc/ir_scan_ctrl.md
IR_SCAN_CTRL -- requirements
Module: ir_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, 8, number of IR channels scanned per round (2..16).
REQ-002 Parameter RES_W, 12, A2D result width in bits.
REQ-003 Parameter ROUND_CYC, 262144, clk cycles per round period.
REQ-004 Parameter SETTLE_CYC, 4096, clk cycles from IR_en rise to first conversion.
REQ-005 Parameter LINE_THRES, 12'h040, line-detect threshold (RES_W bits).
REQ-006 Parameter AVG_LOG2, 2, log2 of samples per channel (0..3).
REQ-007 clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-008 strt_cnv  out  1  one-cycle conversion request to A2D interface.
REQ-009 chnnl  out  $clog2(NUM_CH)  channel under conversion.
REQ-010 cnv_cmplt  in  1  one-cycle conversion-done pulse; res  in  RES_W  result, valid with cnv_cmplt.
REQ-011 IR_en  out  1  IR emitter enable.
REQ-012 ir_vals  out  NUM_CH*RES_W  packed channel results, channel k at bits [k*RES_W +: RES_W].
REQ-013 IR_vld  out  1  one-cycle pulse, full round stored.
REQ-014 line_present  out  1  max reading of last round > LINE_THRES.
REQ-015 max_ch  out  $clog2(NUM_CH)  channel holding last round's maximum.
REQ-016 scan_ovr  out  1  one-cycle pulse, round period expired while scan still busy.

Function
REQ-017 Round timer SHALL count 0..ROUND_CYC-1 and wrap, free-running; "tick" = count equals ROUND_CYC-1.
REQ-018 States SHALL be IDLE, SETTLE, CONV, NEXT, DONE.
REQ-019 IDLE: IR_en=0; on tick -> SETTLE, chnnl cleared to 0, running max and sample counter cleared.
REQ-020 SETTLE: IR_en=1; after SETTLE_CYC cycles in SETTLE, strt_cnv pulses and -> CONV.
REQ-021 CONV: on cnv_cmplt, res added to accumulator of RES_W+AVG_LOG2 bits (no overflow possible).
REQ-022 CONV: if fewer than 2^AVG_LOG2 samples taken, strt_cnv pulses next cycle, same chnnl, stay CONV.
REQ-023 CONV final sample: channel slot loaded with accumulator >> AVG_LOG2 (truncating); -> NEXT.
REQ-024 Running max SHALL update only on strictly greater average; ties keep lower channel index.
REQ-025 NEXT: if chnnl==NUM_CH-1 -> DONE; else chnnl+1, strt_cnv pulses, accumulator cleared, -> CONV.
REQ-026 DONE: IR_vld=1 for exactly one cycle; line_present and max_ch updated same edge; -> IDLE.
REQ-027 IR_en SHALL be 1 in every state except IDLE.
REQ-028 cnv_cmplt outside CONV SHALL be ignored.
REQ-029 Tick while not IDLE: scan_ovr pulses one cycle, scan continues, no restart; next round waits for next tick.
REQ-030 strt_cnv SHALL never be asserted while a conversion is outstanding.

Reset
REQ-031 On rst_n low: state IDLE, timer 0, chnnl 0, ir_vals all 0, max_ch 0, all 1-bit outputs 0.
REQ-032 Reset mid-scan SHALL abandon the round; no IR_vld for it.

Configuration
REQ-033 Macro IR_OVERSAMPLE_EN defined: REQ-021..023 averaging per AVG_LOG2.
REQ-034 Macro undefined: AVG_LOG2 ignored, one sample per channel, res stored directly, no accumulator logic.

Structure
REQ-035 Package ir_pkg SHALL hold state enum type and default LINE_THRES constant.
REQ-036 Sub-module ir_round_timer SHALL implement round timer and tick; ir_scan_ctrl instantiates it once.

Verification
REQ-037 NUM_CH=8, AVG_LOG2=0, A2D model res=0x100+chnnl -> IR_vld once, ir_vals ch7=0x107, max_ch=7, line_present=1.
REQ-038 All res=0x040 -> line_present=0 (strict compare), max_ch=0.
REQ-039 IR_OVERSAMPLE_EN, AVG_LOG2=2, ch3 samples 0x100,0x101,0x102,0x104 -> slot3=0x101.
REQ-040 ROUND_CYC=64, A2D latency 20 cycles -> scan_ovr pulses, no second SETTLE until scan done and next tick.
REQ-041 rst_n low during CONV ch4 -> ir_vals 0, IR_en 0, no IR_vld; next round completes normally.
REQ-042 Spurious cnv_cmplt in IDLE/SETTLE -> no state, slot or max change.
